// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   Turns a valid/ready command stream (read or write) into AXI-Lite master
//   transactions, one outstanding at a time. It returns one response per command
//   and keeps saturating counts of completed writes, completed reads and error
//   responses.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write/addr/wdata/wstrb       command fields (wdata/wstrb ignored on reads)
//   rsp_valid/rsp_ready              response handshake
//   rsp_write/rdata/resp             response fields (rdata = 0 for writes)
//   m_aw_*, m_w_*, m_b_*             AXI-Lite write channels
//   m_ar_*, m_r_*                    AXI-Lite read channels
//   wr_cnt, rd_cnt, err_cnt          saturating statistics counters
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [ADDR_WIDTH-1:0] m_aw_addr,
   output logic                  m_aw_valid,
   input  logic                  m_aw_ready,
   output logic [DATA_WIDTH-1:0] m_w_data,
   output logic [STRB_WIDTH-1:0] m_w_strb,
   output logic                  m_w_valid,
   input  logic                  m_w_ready,
   input  logic [1:0]            m_b_resp,
   input  logic                  m_b_valid,
   output logic                  m_b_ready,
   output logic [ADDR_WIDTH-1:0] m_ar_addr,
   output logic                  m_ar_valid,
   input  logic                  m_ar_ready,
   input  logic [DATA_WIDTH-1:0] m_r_data,
   input  logic [1:0]            m_r_resp,
   input  logic                  m_r_valid,
   output logic                  m_r_ready,
   output logic [CNT_WIDTH-1:0]  wr_cnt,
   output logic [CNT_WIDTH-1:0]  rd_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_valid_q, w_valid_q, ar_valid_q;
   logic                  b_ready_q, r_ready_q;
   logic                  rsp_valid_q, rsp_write_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic [1:0]            rsp_resp_q;
   logic [CNT_WIDTH-1:0]  wr_cnt_q, rd_cnt_q, err_cnt_q;

   // A channel counts as done once its valid has dropped, or when it is
   // handshaking this cycle; both done ends the request phase.
   logic aw_done_d, w_done_d;
   assign aw_done_d = !aw_valid_q || m_aw_ready;
   assign w_done_d  = !w_valid_q  || m_w_ready;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         b_ready_q   <= 1'b0;
         r_ready_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  if (cmd_write) begin
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state_q    <= WR_REQ;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state_q    <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (aw_valid_q && m_aw_ready) aw_valid_q <= 1'b0;
               if (w_valid_q && m_w_ready)   w_valid_q  <= 1'b0;
               if (aw_done_d && w_done_d) begin
                  b_ready_q <= 1'b1;
                  state_q   <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_b_valid) begin
                  b_ready_q   <= 1'b0;
                  rsp_write_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= m_b_resp;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end
            end
            RD_REQ: begin
               if (m_ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (m_r_valid) begin
                  r_ready_q   <= 1'b0;
                  rsp_write_q <= 1'b0;
                  rsp_rdata_q <= m_r_data;
                  rsp_resp_q  <= m_r_resp;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
                  if (rsp_write_q) wr_cnt_q <= sat_inc(wr_cnt_q);
                  else             rd_cnt_q <= sat_inc(rd_cnt_q);
                  if (rsp_resp_q != 2'b00) err_cnt_q <= sat_inc(err_cnt_q);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Ready is decoded from the state register only, so it never follows cmd_valid.
   assign cmd_ready  = (state_q == IDLE) && !rst;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_write  = rsp_write_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_resp   = rsp_resp_q;
   assign m_aw_addr  = addr_q;
   assign m_aw_valid = aw_valid_q;
   assign m_w_data   = wdata_q;
   assign m_w_strb   = wstrb_q;
   assign m_w_valid  = w_valid_q;
   assign m_b_ready  = b_ready_q;
   assign m_ar_addr  = addr_q;
   assign m_ar_valid = ar_valid_q;
   assign m_r_ready  = r_ready_q;
   assign wr_cnt     = wr_cnt_q;
   assign rd_cnt     = rd_cnt_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
module tb_axi_lite_cmd_master;

   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
   logic [3:0]  m_w_strb;
   logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
   logic        m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
   logic [1:0]  m_b_resp, m_r_resp;
   logic [CW-1:0] wr_cnt, rd_cnt, err_cnt;

   always #5 clk = ~clk;

   axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
      .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
      .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
   );

   // ---------------- slave environment: 16-word memory ----------------
   logic        aw_en, w_en, ar_en, rnd_rdy;
   logic        rnd_aw, rnd_w, rnd_ar;
   logic [1:0]  b_resp_cfg, r_resp_cfg;
   logic        aw_have, w_have;
   logic [3:0]  aw_idx;
   logic [31:0] w_d;
   logic [3:0]  w_s;
   logic [31:0] smem [16];
   int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, bad_addr = 0;

   assign m_aw_ready = rnd_rdy ? rnd_aw : aw_en;
   assign m_w_ready  = rnd_rdy ? rnd_w  : w_en;
   assign m_ar_ready = rnd_rdy ? rnd_ar : ar_en;

   always @(posedge clk) begin
      if (rst) begin
         aw_have <= 1'b0; w_have <= 1'b0;
         m_b_valid <= 1'b0; m_b_resp <= 2'b00;
         m_r_valid <= 1'b0; m_r_data <= '0; m_r_resp <= 2'b00;
         for (int i = 0; i < 16; i++) smem[i] <= '0;
      end else begin
         if (m_aw_valid && m_aw_ready) begin
            aw_have <= 1'b1; aw_idx <= m_aw_addr[5:2]; aw_hs <= aw_hs + 1;
            if (m_aw_addr >= 32'd64 || m_aw_addr[1:0] != 2'b00) bad_addr <= bad_addr + 1;
         end
         if (m_w_valid && m_w_ready) begin
            w_have <= 1'b1; w_d <= m_w_data; w_s <= m_w_strb; w_hs <= w_hs + 1;
         end
         if (m_b_valid && m_b_ready) begin
            m_b_valid <= 1'b0; b_hs <= b_hs + 1;
         end
         if (aw_have && w_have) begin
            aw_have <= 1'b0; w_have <= 1'b0;
            for (int i = 0; i < 4; i++)
               if (w_s[i]) smem[aw_idx][8*i +: 8] <= w_d[8*i +: 8];
            m_b_valid <= 1'b1; m_b_resp <= b_resp_cfg;
         end
         if (m_r_valid && m_r_ready) m_r_valid <= 1'b0;
         if (m_ar_valid && m_ar_ready) begin
            m_r_valid <= 1'b1; m_r_data <= smem[m_ar_addr[5:2]]; m_r_resp <= r_resp_cfg;
            ar_hs <= ar_hs + 1;
            if (m_ar_addr >= 32'd64 || m_ar_addr[1:0] != 2'b00) bad_addr <= bad_addr + 1;
         end
      end
   end

   initial begin
      rnd_aw = 1'b1; rnd_w = 1'b1; rnd_ar = 1'b1;
      forever begin
         @(negedge clk);
         rnd_aw = 1'($urandom_range(0, 1));
         rnd_w  = 1'($urandom_range(0, 1));
         rnd_ar = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- reference model and checking ----------------
   int          total = 0, bad = 0;
   logic [31:0] ref_mem [16];
   int          n_wr, n_rd, n_err;
   logic        p_w;
   logic [31:0] p_a, p_d;
   logic [3:0]  p_s;
   logic [1:0]  p_resp;
   logic [31:0] last_rdata;

   function automatic logic [31:0] sat(input int n);
      return (n > (2**CW - 1)) ? 32'(2**CW - 1) : 32'(n);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n_wr = 0; n_rd = 0; n_err = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      chk("accept", {31'b0, cmd_ready}, 32'd1);
      p_w = w; p_a = a; p_d = d; p_s = s;
      p_resp = w ? b_resp_cfg : r_resp_cfg;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic collect();
      int n = 0;
      logic [31:0] exp_d;
      rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!(rsp_valid && rsp_ready) && n < 300) begin
         @(negedge clk); n++;
         rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      chk("rsp_arrives", {31'b0, rsp_valid}, 32'd1);
      if (p_w) begin
         for (int i = 0; i < 4; i++)
            if (p_s[i]) ref_mem[p_a[5:2]][8*i +: 8] = p_d[8*i +: 8];
         exp_d = '0; n_wr++;
      end else begin
         exp_d = ref_mem[p_a[5:2]]; n_rd++;
      end
      if (p_resp != 2'b00) n_err++;
      chk("rsp_write", {31'b0, rsp_write}, {31'b0, p_w});
      chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, p_resp});
      last_rdata = rsp_rdata;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("wr_cnt", {28'b0, wr_cnt}, sat(n_wr));
      chk("rd_cnt", {28'b0, rd_cnt}, sat(n_rd));
      chk("err_cnt", {28'b0, err_cnt}, sat(n_err));
   endtask

   initial begin
      int base, bbase, n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_wstrb = '0; rsp_ready = 1'b0; aw_en = 1'b1; w_en = 1'b1; ar_en = 1'b1;
      rnd_rdy = 1'b0; b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; last_rdata = '0;
      model_reset();
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("rst_valids", {26'b0, m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready, rsp_valid}, 32'd0);
      chk("rst_fields", m_aw_addr | m_w_data | rsp_rdata | {28'b0, m_w_strb} | {30'b0, rsp_resp}, 32'd0);
      chk("rst_cnts", {20'b0, wr_cnt, rd_cnt, err_cnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

      // basic write, read, strobed write
      issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF); collect();
      issue(1'b0, 32'h4, 32'h0, 4'h0);        collect();
      chk("t2_read", last_rdata, 32'hDEADBEEF);
      issue(1'b1, 32'h4, 32'h0000CAFE, 4'h3); collect();
      issue(1'b0, 32'h4, 32'h0, 4'h0);        collect();
      chk("t2_merge", last_rdata, 32'hDEADCAFE);

      // AW first, W three cycles later
      aw_en = 1'b1; w_en = 1'b0; base = aw_hs; bbase = b_hs; n = 0;
      issue(1'b1, 32'h8, 32'h11223344, 4'hF);
      chk("t3_aw_addr", m_aw_addr, 32'h8);
      while (aw_hs == base && n < 50) begin @(negedge clk); n++; end
      chk("t3_aw_hs", 32'(aw_hs - base), 32'd1);
      chk("t3_w_pending", {30'b0, m_aw_valid, m_w_valid}, 32'b01);
      repeat (3) @(negedge clk);
      chk("t3_w_still", {30'b0, m_aw_valid, m_w_valid}, 32'b01);
      w_en = 1'b1; collect();
      chk("t3_single_b", 32'(b_hs - bbase), 32'd1);
      // W first, AW three cycles later
      aw_en = 1'b0; base = w_hs; bbase = b_hs; n = 0;
      issue(1'b1, 32'hC, 32'h55667788, 4'hF);
      while (w_hs == base && n < 50) begin @(negedge clk); n++; end
      chk("t3r_w_hs", 32'(w_hs - base), 32'd1);
      chk("t3r_aw_pending", {30'b0, m_aw_valid, m_w_valid}, 32'b10);
      repeat (3) @(negedge clk);
      aw_en = 1'b1; collect();
      chk("t3r_single_b", 32'(b_hs - bbase), 32'd1);
      issue(1'b0, 32'h8, 32'h0, 4'h0); collect();
      issue(1'b0, 32'hC, 32'h0, 4'h0); collect();

      // response back-pressure
      issue(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
      base = ar_hs; bbase = aw_hs;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("t4_rsp_fields", {29'b0, rsp_write, rsp_resp}, {29'b0, 1'b1, 2'b00});
         chk("t4_rsp_rdata", rsp_rdata, 32'h0);
         chk("t4_no_issue", {29'b0, cmd_ready, m_aw_valid, m_ar_valid}, 32'd0);
      end
      chk("t4_no_hs", 32'((ar_hs - base) + (aw_hs - bbase)), 32'd0);
      cmd_valid = 1'b0;
      collect();

      // reset with AW outstanding
      aw_en = 1'b0;
      issue(1'b1, 32'h14, 32'h12345678, 4'hF);
      chk("t6_aw_up", {31'b0, m_aw_valid}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_valids", {26'b0, m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready, rsp_valid}, 32'd0);
      chk("t6_cnts", {20'b0, wr_cnt, rd_cnt, err_cnt}, 32'd0);
      chk("t6_ready_in_rst", {31'b0, cmd_ready}, 32'd0);
      rst = 1'b0; aw_en = 1'b1; model_reset();
      @(negedge clk);
      chk("t6_ready_after", {31'b0, cmd_ready}, 32'd1);

      // error responses and counter saturation
      b_resp_cfg = 2'b10;
      issue(1'b1, 32'h18, 32'hFEEDF00D, 4'hF); collect();
      b_resp_cfg = 2'b00; r_resp_cfg = 2'b11;
      issue(1'b0, 32'h18, 32'h0, 4'h0); collect();
      r_resp_cfg = 2'b00;
      chk("t5_err_cnt", {28'b0, err_cnt}, 32'd2);
      for (int i = 0; i < 20; i++) begin
         issue(1'b1, 32'(4 * (i % 16)), $urandom, 4'hF); collect();
      end
      chk("t5_wr_sat", {28'b0, wr_cnt}, 32'd15);

      // randomized traffic with random ready/back-pressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         b_resp_cfg = 2'($urandom_range(0, 3));
         r_resp_cfg = 2'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 15)));
         collect();
      end
      rnd_rdy = 1'b0;
      chk("addr_range", 32'(bad_addr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
